// File: rtl/shiftadd_modmul_serialized_pkg.sv
// Shared definitions for the serial shift-add modular arithmetic blocks
// (this multiplier and the companion reducer).
package shiftadd_pkg;

   localparam int DEFAULT_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_t;

endpackage

// File: rtl/shiftadd_modmul_serialized_step.sv
// One interleaved multiply step: acc' = (2*acc + bit*a) mod m, with both
// reductions done by a single conditional subtract each (acc, a < m).
module modmul_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] m_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] acc_o
);

   logic [WIDTH:0] mExt;
   logic [WIDTH:0] dbl;
   logic [WIDTH:0] red1;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] red2;

   // One extra bit is enough: 2*acc and red1+a both stay below 2m.
   always_comb begin
      mExt  = {1'b0, m_i};
      dbl   = {acc_i, 1'b0};
      red1  = (dbl >= mExt) ? (dbl - mExt) : dbl;
      sum   = bit_i ? (red1 + {1'b0, a_i}) : red1;
      red2  = (sum >= mExt) ? (sum - mExt) : sum;
      acc_o = red2[WIDTH-1:0];
   end

endmodule

// File: rtl/shiftadd_modmul_serialized.sv
// Serial interleaved shift-add modular multiplier: result = (a*b) mod m,
// consuming one bit of b per cycle, MSB first.
module shiftadd_modmul_serialized
   import shiftadd_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDXW  = $clog2(WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] m_i,
   input  logic [IDXW-1:0]  m_bl_i,
   output logic [WIDTH-1:0] result_o,
   output logic             valid_o,
   output logic             err_o,
   output logic             busy_o
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             err_q, err_d;

   logic             accept;
   logic             inputErr;
   logic             stepBit;
   logic [WIDTH-1:0] stepAcc;
   logic [WIDTH-1:0] bShifted;
   logic [WIDTH-1:0] mTopBit;
   logic [WIDTH-1:0] mAbove;

   assign accept   = start_i && (state_q != MUL);
   assign bShifted = b_q >> idx_q;
   assign stepBit  = bShifted[0];

   // The m_bl_i range terms guard the shifted top-bit test against wrap-around.
   assign mTopBit  = m_i >> (m_bl_i - IDXW'(1));
   assign mAbove   = m_i >> m_bl_i;
   assign inputErr = (m_i < WIDTH'(2)) || (m_bl_i < IDXW'(2)) || (m_bl_i > IDXW'(WIDTH)) ||
                     !mTopBit[0] || (mAbove != '0) || (a_i >= m_i) || (b_i >= m_i);

   modmul_step #(.WIDTH(WIDTH)) uStep (
      .acc_i (acc_q),
      .a_i   (a_q),
      .m_i   (m_q),
      .bit_i (stepBit),
      .acc_o (stepAcc)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d = inputErr ? DONE : MUL;
            end
         end
         MUL: begin
            if (idx_q == '0) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      a_d   = a_q;
      b_d   = b_q;
      m_d   = m_q;
      idx_d = idx_q;
      err_d = err_q;
      if (accept) begin
         acc_d = '0;
         a_d   = a_i;
         b_d   = b_i;
         m_d   = m_i;
         idx_d = m_bl_i - IDXW'(1);
         err_d = inputErr;
      end else if (state_q == MUL) begin
         acc_d = stepAcc;
         idx_d = idx_q - IDXW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         m_q   <= '0;
         idx_q <= '0;
         err_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         a_q   <= a_d;
         b_q   <= b_d;
         m_q   <= m_d;
         idx_q <= idx_d;
         err_q <= err_d;
      end
   end

   // acc is already fully reduced, so DONE exposes it directly.
   always_comb begin
      valid_o  = (state_q == DONE);
      busy_o   = (state_q == MUL);
      result_o = valid_o ? acc_q : '0;
      err_o    = valid_o && err_q;
   end

endmodule

// File: tb/tb_shiftadd_modmul_serialized.sv
// Self-checking bench for shiftadd_modmul_serialized: directed vector table,
// hand-written control/reset sequences and a randomized run vs. a 128-bit model.
module tb_shiftadd_modmul_serialized;

   localparam logic [63:0] BIGM = 64'hFFFF_FFFF_FFFF_FFC5;

   logic        clk_i;
   logic        rst_ni;
   logic        start_i;
   logic [63:0] a_i;
   logic [63:0] b_i;
   logic [63:0] m_i;
   logic [6:0]  m_bl_i;
   logic [63:0] result_o;
   logic        valid_o;
   logic        err_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] m;
      logic [6:0]  bl;
      logic [63:0] expRes;
      logic        expErr;
      int          expLat;
   } vec_t;

   vec_t vecs[$];

   shiftadd_modmul_serialized dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (start_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .m_i      (m_i),
      .m_bl_i   (m_bl_i),
      .result_o (result_o),
      .valid_o  (valid_o),
      .err_o    (err_o),
      .busy_o   (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic modelErr(input logic [63:0] a, b, m, input logic [6:0] bl);
      int n;
      n = int'(bl);
      if (m < 2 || n < 2 || n > 64) return 1'b1;
      if (m[n-1] != 1'b1) return 1'b1;
      if ((m >> n) != 0) return 1'b1;
      return (a >= m) || (b >= m);
   endfunction

   function automatic logic [63:0] modelRes(input logic [63:0] a, b, m);
      logic [127:0] prod;
      prod = {64'd0, a} * {64'd0, b};
      return 64'(prod % {64'd0, m});
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitValid(input int startLat, output int lat);
      lat = startLat;
      while (!valid_o && lat < 200) begin
         @(posedge clk_i); #1;
         lat++;
      end
      if (!valid_o) lat = -1;
   endtask

   task automatic applyStimulus(input logic [63:0] a, b, m, input logic [6:0] bl,
                                output logic [63:0] res, output logic err, output int lat);
      @(negedge clk_i);
      a_i = a; b_i = b; m_i = m; m_bl_i = bl; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
      m_i = {$urandom, $urandom}; m_bl_i = 7'($urandom);
      waitValid(1, lat);
      res = result_o;
      err = err_o;
   endtask

   initial begin
      logic [63:0] res, a, b, m, mask;
      logic [6:0]  bl;
      logic        err, expErr;
      int          lat;

      rst_ni = 1'b0; start_i = 1'b0;
      a_i = '0; b_i = '0; m_i = '0; m_bl_i = '0;

      vecs.push_back('{"mersenne 5*6",   64'd5,  64'd6,  64'd7,  7'd3, 64'd2, 1'b0, 4});
      vecs.push_back('{"fermat 16*16",   64'd16, 64'd16, 64'd17, 7'd5, 64'd1, 1'b0, 6});
      vecs.push_back('{"fermat 0*13",    64'd0,  64'd13, 64'd17, 7'd5, 64'd0, 1'b0, 6});
      vecs.push_back('{"full (m-1)^2",   BIGM - 1, BIGM - 1, BIGM, 7'd64, 64'd1, 1'b0, 65});
      vecs.push_back('{"full 2^63*2",    64'h8000_0000_0000_0000, 64'd2, BIGM, 7'd64, 64'd59, 1'b0, 65});
      vecs.push_back('{"err m=1",        64'd0,  64'd0,  64'd1,  7'd1, 64'd0, 1'b1, 1});
      vecs.push_back('{"err bl mismatch",64'd1,  64'd1,  64'd7,  7'd4, 64'd0, 1'b1, 1});
      vecs.push_back('{"err a>=m",       64'd7,  64'd1,  64'd7,  7'd3, 64'd0, 1'b1, 1});
      vecs.push_back('{"err bl=65",      64'd1,  64'd1,  64'd7,  7'd65, 64'd0, 1'b1, 1});
      vecs.push_back('{"m=2 1*1",        64'd1,  64'd1,  64'd2,  7'd2, 64'd1, 1'b0, 3});

      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("reset valid",  64'(valid_o),  64'd0);
      checkOutput("reset busy",   64'(busy_o),   64'd0);
      checkOutput("reset result", result_o,      64'd0);
      checkOutput("reset err",    64'(err_o),    64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].bl, res, err, lat);
         checkOutput({vecs[i].name, " result"},  res,        vecs[i].expRes);
         checkOutput({vecs[i].name, " err"},     64'(err),   64'(vecs[i].expErr));
         checkOutput({vecs[i].name, " latency"}, 64'(lat),   64'(vecs[i].expLat));
      end

      // start pulsed mid-operation must be ignored
      @(negedge clk_i);
      a_i = 64'd16; b_i = 64'd16; m_i = 64'd17; m_bl_i = 7'd5; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      checkOutput("busy in MUL", 64'(busy_o), 64'd1);
      @(negedge clk_i);
      a_i = 64'd1; b_i = 64'd1; m_i = 64'd7; m_bl_i = 7'd3; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      waitValid(2, lat);
      checkOutput("mid-MUL start result",  result_o, 64'd1);
      checkOutput("mid-MUL start latency", 64'(lat), 64'd6);

      repeat (5) @(posedge clk_i);
      #1;
      checkOutput("hold valid",  64'(valid_o), 64'd1);
      checkOutput("hold result", result_o,     64'd1);
      checkOutput("hold busy",   64'(busy_o),  64'd0);

      // back-to-back start from DONE
      @(negedge clk_i);
      a_i = 64'd5; b_i = 64'd6; m_i = 64'd7; m_bl_i = 7'd3; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      checkOutput("b2b valid drop",  64'(valid_o), 64'd0);
      checkOutput("b2b result zero", result_o,     64'd0);
      waitValid(1, lat);
      checkOutput("b2b result",  result_o, 64'd2);
      checkOutput("b2b latency", 64'(lat), 64'd4);

      // reset in the middle of an operation
      @(negedge clk_i);
      a_i = 64'd16; b_i = 64'd16; m_i = 64'd17; m_bl_i = 7'd5; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      checkOutput("mid reset busy",   64'(busy_o),  64'd0);
      checkOutput("mid reset valid",  64'(valid_o), 64'd0);
      checkOutput("mid reset result", result_o,     64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (6) @(posedge clk_i);
      #1;
      checkOutput("aborted stays idle", 64'(valid_o), 64'd0);
      applyStimulus(64'd3, 64'd3, 64'd7, 7'd3, res, err, lat);
      checkOutput("post reset result",  res,      64'd2);
      checkOutput("post reset latency", 64'(lat), 64'd4);

      // randomized run against the arithmetic model
      for (int n = 0; n < 800; n++) begin
         bl   = 7'($urandom_range(2, 64));
         mask = (bl == 7'd64) ? '1 : ((64'd1 << bl) - 64'd1);
         m    = ({$urandom, $urandom} & mask) | (64'd1 << (bl - 7'd1));
         a    = {$urandom, $urandom} % m;
         b    = {$urandom, $urandom} % m;
         case ($urandom_range(0, 15))
            0:       a  = m;
            1:       bl = bl + 7'd1;
            2:       bl = 7'($urandom_range(0, 127));
            default: ;
         endcase
         expErr = modelErr(a, b, m, bl);
         applyStimulus(a, b, m, bl, res, err, lat);
         checkOutput($sformatf("rand %0d err", n), 64'(err), 64'(expErr));
         checkOutput($sformatf("rand %0d result", n), res, expErr ? 64'd0 : modelRes(a, b, m));
         checkOutput($sformatf("rand %0d latency", n), 64'(lat), expErr ? 64'd1 : 64'(int'(bl) + 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
